dmem_line_responder: RTL and testbench

//  Memory-side responder for the 256-bit line transfer interface driven by the data cache controller.

---
 rtl/dmem_line_responder.sv | 115 +++++++++++
 tb/tb_dmem_line_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dmem_line_responder.sv
// dmem_line_responder
// Memory-side responder for the 256-bit dcache line interface. One request
// at a time; each completes LATENCY edges after acceptance with a one-cycle
// ack. Reads return data in the ack cycle. The storage is a line-wide array
// that is never reset.
module dmem_line_responder #(
    parameter int LATENCY = 10,
    parameter int LINE_AW = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
);

    localparam int DEPTH = 1 << LINE_AW;

    // Loaded at acceptance. Counting down to zero and then taking one more
    // edge places the ack edge exactly LATENCY edges after acceptance. This
    // also holds for LATENCY=1, so no separate path is needed.
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t               state_q;
    logic [7:0]           cnt_q;
    logic [LINE_AW-1:0]   idx_q;
    logic                 wr_q;
    logic [255:0]         wdata_q;
    logic                 ack_q;
    logic [255:0]         rdata_q;

    logic [255:0]         mem_q [DEPTH];

    logic [LINE_AW-1:0]   idx_in;
    logic                 done;
    logic                 unused_addr;

    // Only the line index participates; offset and high bits alias.
    assign idx_in      = addr_i[LINE_AW+4:5];
    assign unused_addr = ^{addr_i[31:LINE_AW+5], addr_i[4:0]};

    // Final edge of a live request: the requester is still asserting
    // enable_i and the countdown has expired.
    assign done = (state_q == S_BUSY) && enable_i && (cnt_q == 8'd0);

    assign ack_o  = ack_q;
    assign data_o = rdata_q;

    // Line array write port. A write commits only on the edge entering
    // ACK, so an abort or reset before that edge leaves the line unchanged.
    always_ff @(posedge clk_i) begin
        if (done && wr_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    // Request FSM with registered ack and read-data outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    ack_q <= 1'b0;
                    if (enable_i) begin
                        idx_q   <= idx_in;
                        wr_q    <= write_i;
                        wdata_q <= data_i;
                        cnt_q   <= CNT_INIT;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!enable_i) begin
                        // Requester withdrew: drop the request silently.
                        state_q <= S_IDLE;
                    end else if (cnt_q == 8'd0) begin
                        state_q <= S_ACK;
                        ack_q   <= 1'b1;
                        if (!wr_q) begin
                            rdata_q <= mem_q[idx_q];
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_ACK: begin
                    // enable_i is deliberately ignored at this edge.
                    ack_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_line_responder.sv
// Testbench for dmem_line_responder: one LATENCY=10 instance driven from a
// vector table plus abort/reset sequences, and one LATENCY=1 instance.
module tb_dmem_line_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en0, wr0, en1, wr1;
    logic [31:0]  addr0, addr1;
    logic [255:0] din0, din1;
    logic         ack0, ack1;
    logic [255:0] dout0, dout1;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [255:0] last_rd0 = '0;
    logic [255:0] last_rd1 = '0;

    always #5 clk = ~clk;

    dmem_line_responder #(.LATENCY(10), .LINE_AW(9)) u0 (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en0), .write_i(wr0),
        .addr_i(addr0), .data_i(din0), .ack_o(ack0), .data_o(dout0)
    );

    dmem_line_responder #(.LATENCY(1), .LINE_AW(9)) u1 (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en1), .write_i(wr1),
        .addr_i(addr1), .data_i(din1), .ack_o(ack1), .data_o(dout1)
    );

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
        logic [255:0] exp_rd;
        string        name;
    } vec_t;

    vec_t vecs[10];

    localparam logic [255:0] PAT_A5 = {32{8'hA5}};
    localparam logic [255:0] PAT_DB = {8{32'hDEADBEEF}};
    localparam logic [255:0] PAT_Q  = {16{16'hC3E1}};
    localparam logic [255:0] PAT_V1 = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [255:0] PAT_V2 = {4{64'hFEDC_BA98_7654_3210}};

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One full transaction on instance sel; checks ack latency, data in the
    // ack cycle, and that ack is a single-cycle pulse.
    task automatic req(input bit sel, input logic wr, input logic [31:0] addr,
                       input logic [255:0] data, input logic [255:0] exp_rd,
                       input int lat, input string nm);
        int k;
        bit got;
        logic [255:0] exp_d;
        logic [255:0] held;
        if (sel) begin en1 = 1'b1; wr1 = wr; addr1 = addr; din1 = data; end
        else     begin en0 = 1'b1; wr0 = wr; addr0 = addr; din0 = data; end
        @(posedge clk);
        #1;
        // Operands change after acceptance; the DUT must ignore this.
        if (sel) begin wr1 = ~wr; addr1 = ~addr; din1 = ~data; end
        else     begin wr0 = ~wr; addr0 = ~addr; din0 = ~data; end
        k = 0;
        got = 1'b0;
        while (!got && k < lat + 20) begin
            @(posedge clk);
            #1;
            k++;
            if ((sel ? ack1 : ack0) == 1'b1) got = 1'b1;
        end
        chk({nm, " ack_latency"}, 256'(k), 256'(lat));
        exp_d = wr ? (sel ? last_rd1 : last_rd0) : exp_rd;
        held = sel ? dout1 : dout0;
        if (got) begin
            chk({nm, " data_o"}, held, exp_d);
            if (!wr) begin
                if (sel) last_rd1 = exp_rd; else last_rd0 = exp_rd;
            end
        end
        if (sel) en1 = 1'b0; else en0 = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, " ack_pulse_end"}, 256'(sel ? ack1 : ack0), 256'(0));
        chk({nm, " data_o_hold"}, sel ? dout1 : dout0, exp_d);
        $display("txn %s inst=%0d wr=%0d addr=%h lat=%0d", nm, sel, wr, addr, k);
    endtask

    initial begin
        int acks;

        vecs[0] = '{1'b1, 32'h0000_0020, PAT_A5, '0,           "wr_line1"};
        vecs[1] = '{1'b0, 32'h0000_0020, '0,     PAT_A5,       "rd_line1"};
        vecs[2] = '{1'b1, 32'h0000_0040, 256'h1234, '0,        "wr_0x40"};
        vecs[3] = '{1'b0, 32'h0000_0040, '0,     256'h1234,    "rd_0x40"};
        vecs[4] = '{1'b1, 32'h0000_03E0, PAT_DB, '0,           "wb_0x3E0"};
        vecs[5] = '{1'b0, 32'h0000_43E0, '0,     PAT_DB,       "refill_alias_0x43E0"};
        vecs[6] = '{1'b0, 32'h0000_4020, '0,     PAT_A5,       "rd_alias_0x4020"};
        vecs[7] = '{1'b1, 32'h0000_005F, PAT_Q,  '0,           "wr_offset_0x5F"};
        vecs[8] = '{1'b0, 32'hFFFF_C040, '0,     PAT_Q,        "rd_hibits_0x40"};
        vecs[9] = '{1'b1, 32'h0000_00A0, PAT_V1, '0,           "wr_0xA0"};

        rst_n = 1'b0;
        en0 = 1'b0; wr0 = 1'b0; addr0 = '0; din0 = '0;
        en1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ack0", 256'(ack0), 256'(0));
        chk("reset data0", dout0, '0);
        chk("reset ack1", 256'(ack1), 256'(0));
        chk("reset data1", dout1, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back table transactions on the LATENCY=10 instance.
        for (int i = 0; i < 10; i++) begin
            req(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_rd, 10, vecs[i].name);
        end

        // Abort: write accepted at E0, enable dropped before edge E0+4.
        en0 = 1'b1; wr0 = 1'b1; addr0 = 32'h0000_0040; din0 = PAT_V2;
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        en0 = 1'b0;
        acks = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (ack0) acks++;
        end
        chk("abort no_ack", 256'(acks), 256'(0));
        $display("txn abort_wr_0x40 acks=%0d", acks);
        req(1'b0, 1'b0, 32'h0000_0040, '0, PAT_Q, 10, "rd_after_abort");

        // Reset in the middle of a write to line 0xA0.
        en0 = 1'b1; wr0 = 1'b1; addr0 = 32'h0000_00A0; din0 = PAT_V2;
        @(posedge clk);
        #1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        en0 = 1'b0;
        #1;
        chk("midreset ack0", 256'(ack0), 256'(0));
        chk("midreset data0", dout0, '0);
        $display("txn reset_mid_write data0=%h", dout0);
        last_rd0 = '0;
        last_rd1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req(1'b0, 1'b0, 32'h0000_00A0, '0, PAT_V1, 10, "rd_after_reset");

        // LATENCY=1 instance.
        req(1'b1, 1'b1, 32'h0000_0060, PAT_V2, '0, 1, "l1_wr_0x60");
        req(1'b1, 1'b0, 32'h0000_0060, '0, PAT_V2, 1, "l1_rd_0x60");
        req(1'b1, 1'b0, 32'h0000_4060, '0, PAT_V2, 1, "l1_rd_alias_0x4060");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
